// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with 3-sample mid-bit majority vote, 8N1.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity-error strobe.
module uart_rx_os #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state;
    logic          sync_0, rx_s, rx_d;
    logic [CW-1:0] cnt;
    logic [3:0]    tcnt;
    logic [2:0]    bcnt;
    logic [7:0]    shift;
    logic          s0, s1, last;
    logic          tick, maj, decide, wrap;

    assign tick   = state != IDLE && cnt == CW'(DIV - 1);
    assign maj    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign decide = tick && tcnt == 4'd9;
    assign wrap   = tick && tcnt == 4'd15;
    assign o_busy = state != IDLE;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_0      <= 1'b1;
            rx_s        <= 1'b1;
            rx_d        <= 1'b1;
            cnt         <= '0;
            tcnt        <= '0;
            bcnt        <= '0;
            shift       <= '0;
            s0          <= 1'b1;
            s1          <= 1'b1;
            last        <= 1'b0;
            state       <= IDLE;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            sync_0      <= i_in;
            rx_s        <= sync_0;
            rx_d        <= rx_s;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            if (tick) tcnt <= tcnt + 1'b1;
            if (tick && tcnt == 4'd7) s0 <= rx_s;
            if (tick && tcnt == 4'd8) s1 <= rx_s;
            case (state)
                // tcnt starts at 2 so every tcnt==9 decision lands exactly on a mid-bit point
                IDLE: if (rx_d && !rx_s) begin
                    state <= START;
                    tcnt  <= 4'd2;
                    bcnt  <= '0;
                    last  <= 1'b0;
                end
                START: if (decide) state <= maj ? IDLE : DATA;
                DATA: begin
                    if (decide) begin
                        shift <= {maj, shift[7:1]};
                        bcnt  <= bcnt + 1'b1;
                        last  <= bcnt == 3'd7;
                    end
`ifdef UART_RX_PARITY_EN
                    if (wrap && last) state <= PARITY;
`else
                    if (wrap && last) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decide) par_bad <= ^{shift, maj};
                    if (wrap) state <= STOP;
                end
`endif
                STOP: if (decide) begin
                    if (!maj) begin
                        o_frame_err <= 1'b1;
                        state       <= BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        o_parity_err <= 1'b1;
                        state        <= IDLE;
`endif
                    end else begin
                        o_data  <= shift;
                        o_valid <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
